// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares the two byte-wide RAM banks (bank0 = even bytes, bank1 = odd bytes)
//   between the CPU data port and the video fetch engine. Video has priority;
//   a streak limiter forces a CPU grant after VID_STREAK consecutive video
//   grants while the CPU waits. CPU accesses are byte-lane steered so 8/16-bit
//   little-endian accesses work at any byte address, wrapping at 0xFFFF.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cpu_req/wr/wide/addr/wdata CPU request, held stable until cpu_ready
//   cpu_ready                  combinational grant
//   cpu_rvalid/cpu_rdata       read return at grant+1 (8-bit reads zero-extended)
//   vid_req/vid_addr           video word fetch request
//   vid_ack                    combinational grant
//   vid_rvalid/vid_rdata       fetch return at grant+1, {bank1, bank0}
//   bankN_addr/we/wdata        bank controls, driven in the grant cycle
//   bankN_rdata                synchronous bank read data (1-cycle latency)
//   cpu_stall_cycles           saturating count of cpu_req && !cpu_ready
//
// Build option
//   VRAM_ARBITER_STATS_EN      enables the cpu_stall_cycles counter; when
//                              undefined the output is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant in the previous cycle, nothing returning
// GNT_VID | video granted in the previous cycle, its data returns now
// GNT_CPU | CPU granted in the previous cycle, read data returns now

module vram_arbiter #(
  parameter int VID_STREAK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic        cpu_wide,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_rvalid,
  output logic [15:0] vid_rdata,
  output logic [14:0] bank0_addr,
  output logic [14:0] bank1_addr,
  output logic        bank0_we,
  output logic        bank1_we,
  output logic [7:0]  bank0_wdata,
  output logic [7:0]  bank1_wdata,
  input  logic [7:0]  bank0_rdata,
  input  logic [7:0]  bank1_rdata,
  output logic [15:0] cpu_stall_cycles
);

  localparam int SW = (VID_STREAK < 1) ? 1 : $clog2(VID_STREAK + 1);

  typedef enum logic [1:0] {IDLE, GNT_VID, GNT_CPU} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          ret_rd, ret_a0, ret_wide;
  logic [14:0]   hold0, hold1;
  logic          streak_full, vid_gnt, cpu_gnt;

  assign streak_full = (streak == SW'(VID_STREAK));

  // Grants are suppressed while reset is asserted so no bank access or
  // handshake leaks out during reset.
  assign vid_gnt   = rst_n && vid_req && !(streak_full && cpu_req);
  assign cpu_gnt   = rst_n && cpu_req && !vid_gnt;
  assign vid_ack   = vid_gnt;
  assign cpu_ready = cpu_gnt;

  // Bank steering. For an odd CPU address the low byte lives in bank1 and the
  // high byte in bank0 of the next word (wrapping to word 0 at 0xFFFF).
  always_comb begin
    bank0_addr  = hold0;
    bank1_addr  = hold1;
    bank0_we    = 1'b0;
    bank1_we    = 1'b0;
    bank0_wdata = 8'h00;
    bank1_wdata = 8'h00;
    if (vid_gnt) begin
      bank0_addr = vid_addr;
      bank1_addr = vid_addr;
    end else if (cpu_gnt) begin
      bank1_addr = cpu_addr[15:1];
      bank0_addr = cpu_addr[0] ? cpu_addr[15:1] + 15'd1 : cpu_addr[15:1];
      bank0_we   = cpu_wr && (cpu_wide || !cpu_addr[0]);
      bank1_we   = cpu_wr && (cpu_wide ||  cpu_addr[0]);
      if (cpu_addr[0]) begin
        bank1_wdata = cpu_wdata[7:0];
        bank0_wdata = cpu_wdata[15:8];
      end else begin
        bank0_wdata = cpu_wdata[7:0];
        bank1_wdata = cpu_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      streak   <= '0;
      ret_rd   <= 1'b0;
      ret_a0   <= 1'b0;
      ret_wide <= 1'b0;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      hold0    <= bank0_addr;
      hold1    <= bank1_addr;
      ret_rd   <= cpu_gnt && !cpu_wr;
      ret_a0   <= cpu_addr[0];
      ret_wide <= cpu_wide;
      if (vid_gnt)      state <= GNT_VID;
      else if (cpu_gnt) state <= GNT_CPU;
      else              state <= IDLE;
      if (cpu_gnt || !cpu_req)
        streak <= '0;
      else if (vid_gnt && !streak_full)
        streak <= streak + SW'(1);
    end
  end

  assign vid_rvalid = (state == GNT_VID);
  assign cpu_rvalid = (state == GNT_CPU) && ret_rd;

  always_comb begin
    cpu_rdata = 16'h0000;
    vid_rdata = 16'h0000;
    if (vid_rvalid)
      vid_rdata = {bank1_rdata, bank0_rdata};
    if (cpu_rvalid) begin
      if (ret_wide)
        cpu_rdata = ret_a0 ? {bank0_rdata, bank1_rdata} : {bank1_rdata, bank0_rdata};
      else
        cpu_rdata = {8'h00, ret_a0 ? bank1_rdata : bank0_rdata};
    end
  end

`ifdef VRAM_ARBITER_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= 16'h0000;
    else if (cpu_req && !cpu_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign cpu_stall_cycles = stall_q;
`else
  assign cpu_stall_cycles = 16'h0000;
`endif

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port arbiter sharing the two byte-wide RAM banks (bank0 = even byte addresses, bank1 = odd byte addresses) between the CPU data port and the video fetch engine. Video fetches take priority so scan-out never underruns. A streak limiter guarantees CPU forward progress. The block sits between `cpu`/`video` and `mem`, replacing their direct wiring. It also performs byte-lane steering, so the CPU sees little-endian 8/16-bit accesses at any byte address, including odd addresses.

## Interface
- `VID_STREAK`, default 8: maximum consecutive video grants while a CPU request is waiting.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held with stable fields until accepted.
- `cpu_wr`  in  1  1 = write, 0 = read.
- `cpu_wide`  in  1  1 = 16-bit, 0 = 8-bit.
- `cpu_addr`  in  16  byte address.
- `cpu_wdata`  in  16  write data; the low byte is used for 8-bit writes.
- `cpu_ready`  out  1  combinational grant; the access is accepted on an edge where `cpu_req && cpu_ready`.
- `cpu_rvalid`  out  1  read data valid, exactly one cycle after acceptance of a read.
- `cpu_rdata`  out  16  read data; 8-bit reads return `{8'h00, byte}`.
- `vid_req`  in  1  video fetch request.
- `vid_addr`  in  15  word address of the fetch (both banks).
- `vid_ack`  out  1  combinational grant.
- `vid_rvalid`  out  1  fetch data valid, one cycle after acceptance.
- `vid_rdata`  out  16  `{bank1, bank0}`.
- `bank0_addr`, `bank1_addr`  out  15  bank word addresses.
- `bank0_we`, `bank1_we`  out  1  bank write enables.
- `bank0_wdata`, `bank1_wdata`  out  8  bank write data.
- `bank0_rdata`, `bank1_rdata`  in  8  synchronous read data, valid one cycle after the address is presented.
- `cpu_stall_cycles`  out  16  see Configuration.

## Operation
- At most one grant per cycle.
- Priority:
  - Video wins when `vid_req`, unless the streak counter has reached `VID_STREAK` and `cpu_req` is high. In that case the CPU is granted and video waits.
- Streak counter:
  - Increments on each video grant while `cpu_req` is high.
  - Clears on any CPU grant, and on any cycle where `cpu_req` is low.
  - Saturates at `VID_STREAK`.
- Lane mapping:
  - Byte address A maps to bank `A[0]`, word `A[15:1]`.
  - A wide access reads or writes the low byte at A and the high byte at A+1. The address wraps modulo 2^16, so the high byte of a wide access at 0xFFFF is at 0x0000.
  - An odd wide access uses bank1 word `A>>1` and bank0 word `(A+1)>>1` in the same single cycle.
- Bank write enables:
  - Byte write: only the addressed bank is write-enabled.
  - Wide write: both banks are write-enabled.
  - Reads: neither bank is write-enabled.
- Read-return pipeline:
  - Registered at grant: owner (cpu/vid), `A[0]`, width.
  - Used next cycle to steer `bankN_rdata` into `cpu_rdata`/`vid_rdata`.
- Writes produce no `cpu_rvalid`.
- Idle cycles: bank addresses hold their last value and write enables are 0.
- States: IDLE (no grant), GNT_VID, GNT_CPU. The state is re-evaluated every cycle, so back-to-back grants to the same requester have no bubble.

## Timing
- `cpu_ready` and `vid_ack` are combinational from `vid_req`, `cpu_req` and the streak counter. There are no combinational paths from bank inputs to them.
- Bank outputs are driven in the grant cycle.
- `*_rvalid` and `*_rdata` are registered and appear at grant+1.
- Read latency is 1 cycle; write latency is 0 cycles (committed at the grant edge).
- Reset:
  - Both `rvalid` outputs are 0, the streak counter is 0, write enables are 0, and all data and address outputs are 0.
  - An in-flight read return is discarded; no `rvalid` follows a deasserting reset.
- Worst-case CPU wait with continuous video requests is `VID_STREAK` cycles.

## Configuration
- `VRAM_ARBITER_STATS_EN` defined:
  - `cpu_stall_cycles` counts cycles with `cpu_req && !cpu_ready`.
  - The counter saturates at 0xFFFF and clears on reset.
- Not defined: `cpu_stall_cycles` is tied to 0 and the counter logic is absent.

## Test plan
- Aligned wide access: CPU wide write 0xBEEF at 0x1000, then wide read at 0x1000.
  - Required: bank0 word 0x0800 = 0xEF and bank1 word 0x0800 = 0xBE.
  - Required: `cpu_rvalid` at grant+1 with `cpu_rdata` = 0xBEEF.
- Odd and wrapping wide writes: CPU wide write 0x1234 at 0x1001, and wide write 0xA55A at 0xFFFF.
  - 0x1001 required: bank1[0x0800] = 0x34 and bank0[0x0801] = 0x12, both in one cycle.
  - 0xFFFF required: bank1[0x7FFF] = 0x5A and bank0[0x0000] = 0xA5.
- Byte access: byte write 0x7E at 0x2003, then byte read at 0x2003.
  - Required: only `bank1_we` asserted on the write.
  - Required: read returns 0x007E; bank0[0x1001] is unchanged.
- Collision and starvation guard: `vid_req` held high continuously, with `cpu_req` raised at cycle 0.
  - With `VID_STREAK` = 8, required: video granted in cycles 0–7 and CPU granted in cycle 8, then video resumes.
  - With the macro defined, required: `cpu_stall_cycles` = 8.
- Reset mid-read: assert `rst_n` low in the cycle a CPU read is granted.
  - Required: no `cpu_rvalid`, all outputs 0.
  - Required: after release, the first `vid_req` is acknowledged in the same cycle.
- Interleaved traffic: alternate video and CPU reads every cycle.
  - Required: each `rvalid` pulse is routed to the correct requester with the correct data, and there are no dropped or duplicated returns.
